// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter for the single HPS-bridge sdram slave port.
// m0 is instruction fetch, m1 is data load/store. The command path is registered.
// A per-transaction timeout guarantees that every granted request is acknowledged,
// even when the bridge stalls.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byte_enable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_write_data,
  output logic                m0_acknowledge,
  output logic [DATA_W-1:0]   m0_read_data,
  output logic                m0_error,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byte_enable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_write_data,
  output logic                m1_acknowledge,
  output logic [DATA_W-1:0]   m1_read_data,
  output logic                m1_error,

  output logic [ADDR_W-1:0]   sdram_address,
  output logic [DATA_W/8-1:0] sdram_byte_enable,
  output logic                sdram_read,
  output logic                sdram_write,
  output logic [DATA_W-1:0]   sdram_write_data,
  input  logic                sdram_acknowledge,
  input  logic [DATA_W-1:0]   sdram_read_data
);

  localparam int unsigned BE_W       = DATA_W / 8;
  // The counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_LAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic               grant_q;       // requester owning the current transaction
  logic               last_grant_q;  // requester granted most recently
  logic               err_q;         // current transaction timed out
  logic [CNT_W-1:0]   cnt_q;

  logic               req0, req1;
  logic               grant_sel;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BE_W-1:0]    sel_be;
  logic [DATA_W-1:0]  sel_wdata;
  logic               timed_out;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Round-robin pick: a sole requester wins; on a tie, the requester not granted last wins.
  always_comb begin
    if (req0 && req1) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = req1;
    end
  end

  // Mux the winning requester's command. Write takes priority when both strobes are set.
  always_comb begin
    if (grant_sel) begin
      sel_wr    = m1_write;
      sel_addr  = m1_address;
      sel_be    = m1_byte_enable;
      sel_wdata = m1_write_data;
    end else begin
      sel_wr    = m0_write;
      sel_addr  = m0_address;
      sel_be    = m0_byte_enable;
      sel_wdata = m0_write_data;
    end
  end

  // Timeout fires on the last allowed BUSY cycle. An acknowledge in that same cycle wins.
  always_comb begin
    timed_out = TIMEOUT_EN && !sdram_acknowledge && (cnt_q == CNT_W'(CNT_LAST));
  end

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (sdram_acknowledge || timed_out) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: one-cycle completion pulse to the granted requester.
  always_comb begin
    m0_acknowledge = 1'b0;
    m0_error       = 1'b0;
    m1_acknowledge = 1'b0;
    m1_error       = 1'b0;
    if (state_q == StDone) begin
      if (grant_q) begin
        m1_acknowledge = 1'b1;
        m1_error       = err_q;
      end else begin
        m0_acknowledge = 1'b1;
        m0_error       = err_q;
      end
    end
  end

  // Command path, timeout counter and per-requester read-data capture.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      grant_q           <= 1'b0;
      last_grant_q      <= 1'b1;
      err_q             <= 1'b0;
      cnt_q             <= '0;
      sdram_address     <= '0;
      sdram_byte_enable <= '0;
      sdram_read        <= 1'b0;
      sdram_write       <= 1'b0;
      sdram_write_data  <= '0;
      m0_read_data      <= '0;
      m1_read_data      <= '0;
    end else begin
      if (state_q == StIdle) begin
        if (req0 || req1) begin
          grant_q           <= grant_sel;
          last_grant_q      <= grant_sel;
          err_q             <= 1'b0;
          cnt_q             <= '0;
          sdram_address     <= sel_addr;
          sdram_byte_enable <= sel_wr ? sel_be : {BE_W{1'b1}};
          sdram_read        <= ~sel_wr;
          sdram_write       <= sel_wr;
          sdram_write_data  <= sel_wdata;
        end
      end else if (state_q == StBusy) begin
        if (sdram_acknowledge) begin
          sdram_read  <= 1'b0;
          sdram_write <= 1'b0;
          if (sdram_read) begin
            if (grant_q) begin
              m1_read_data <= sdram_read_data;
            end else begin
              m0_read_data <= sdram_read_data;
            end
          end
        end else if (timed_out) begin
          sdram_read  <= 1'b0;
          sdram_write <= 1'b0;
          err_q       <= 1'b1;
          if (grant_q) begin
            m1_read_data <= '0;
          end else begin
            m0_read_data <= '0;
          end
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter. The main process issues requests and plays the
// bridge. Each time a transaction is issued, the expected completion is queued. A negedge
// monitor pops that entry and checks it against the acknowledge the DUT presents.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_write_data, m1_write_data;
  logic        m0_acknowledge, m1_acknowledge, m0_error, m1_error;
  logic [31:0] m0_read_data, m1_read_data;
  logic [15:0] sdram_address;
  logic [3:0]  sdram_byte_enable;
  logic        sdram_read, sdram_write, sdram_acknowledge;
  logic [31:0] sdram_write_data, sdram_read_data;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W (16),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .m0_address       (m0_address),
    .m0_byte_enable   (m0_byte_enable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_write_data    (m0_write_data),
    .m0_acknowledge   (m0_acknowledge),
    .m0_read_data     (m0_read_data),
    .m0_error         (m0_error),
    .m1_address       (m1_address),
    .m1_byte_enable   (m1_byte_enable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_write_data    (m1_write_data),
    .m1_acknowledge   (m1_acknowledge),
    .m1_read_data     (m1_read_data),
    .m1_error         (m1_error),
    .sdram_address    (sdram_address),
    .sdram_byte_enable(sdram_byte_enable),
    .sdram_read       (sdram_read),
    .sdram_write      (sdram_write),
    .sdram_write_data (sdram_write_data),
    .sdram_acknowledge(sdram_acknowledge),
    .sdram_read_data  (sdram_read_data)
  );

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd_hold[2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every requester acknowledge must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m0_acknowledge || m1_acknowledge) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got m0=%b m1=%b expected none",
                 m0_acknowledge, m1_acknowledge);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {31'd0, m1_acknowledge}, {31'd0, e.port});
        chk("ack_single", {31'd0, m0_acknowledge & m1_acknowledge}, 32'd0);
        chk("ack_data", e.port ? m1_read_data : m0_read_data, e.data);
        chk("ack_error", {31'd0, e.port ? m1_error : m0_error}, {31'd0, e.err});
      end
    end
  end

  task automatic req(input bit p, input bit wr, input logic [15:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
    if (p) begin
      m1_address = a; m1_byte_enable = be; m1_write_data = wd;
      m1_write = wr;  m1_read = ~wr;
    end else begin
      m0_address = a; m0_byte_enable = be; m0_write_data = wd;
      m0_write = wr;  m0_read = ~wr;
    end
  endtask

  task automatic drop(input bit p);
    if (p) begin
      m1_read = 1'b0; m1_write = 1'b0;
    end else begin
      m0_read = 1'b0; m0_write = 1'b0;
    end
  endtask

  // Play the bridge for one transaction. The ack is raised `delay` cycles after the strobe
  // is first seen. Then check the strobe length and the requester ack timing.
  task automatic serve(input bit p, input bit wr, input logic [15:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input int delay, input logic [31:0] rd,
                       input bit noack, input int exp_cyc, output int waited);
    exp_t e;
    int   n;
    e.port = p;
    if (noack) begin
      e.data = 32'd0; e.err = 1'b0; e.err = 1'b1; rd_hold[p] = 32'd0;
    end else if (!wr) begin
      e.data = rd; e.err = 1'b0; rd_hold[p] = rd;
    end else begin
      e.data = rd_hold[p]; e.err = 1'b0;
    end
    sb.push_back(e);
    waited = 0;
    while (!(sdram_read || sdram_write) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_wait: got no strobe in 20 cycles expected strobe");
      drop(p);
      return;
    end
    chk("sdram_address", {16'd0, sdram_address}, {16'd0, a});
    chk("sdram_be", {28'd0, sdram_byte_enable}, {28'd0, wr ? be : 4'hF});
    chk("sdram_read", {31'd0, sdram_read}, {31'd0, ~wr});
    chk("sdram_write", {31'd0, sdram_write}, {31'd0, wr});
    if (wr) chk("sdram_wdata", sdram_write_data, wd);
    n = 0;
    while ((sdram_read || sdram_write) && n < 64) begin
      sdram_acknowledge = !noack && (n == delay);
      sdram_read_data   = rd;
      @(negedge clk);
      n++;
    end
    sdram_acknowledge = 1'b0;
    sdram_read_data   = 32'h5A5A_5A5A;
    chk("strobe_cycles", n, exp_cyc);
    chk("req_ack_latency", {31'd0, p ? m1_acknowledge : m0_acknowledge}, 32'd1);
    drop(p);
  endtask

  initial begin
    int w;
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    m0_address = '0; m0_byte_enable = '0; m0_read = 0; m0_write = 0; m0_write_data = '0;
    m1_address = '0; m1_byte_enable = '0; m1_read = 0; m1_write = 0; m1_write_data = '0;
    sdram_acknowledge = 1'b0;
    sdram_read_data = 32'h5A5A_5A5A;
    rd_hold[0] = 32'd0;
    rd_hold[1] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_sdram_read", {31'd0, sdram_read}, 32'd0);
    chk("rst_sdram_write", {31'd0, sdram_write}, 32'd0);
    chk("rst_sdram_address", {16'd0, sdram_address}, 32'd0);
    chk("rst_acks", {30'd0, m0_acknowledge, m1_acknowledge}, 32'd0);
    chk("rst_m0_rdata", m0_read_data, 32'd0);
    rst_n = 1'b1;

    // T1: m1 read, bridge acks 2 cycles after strobe.
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0010, 4'h0, 32'd0);
    serve(1'b1, 1'b0, 16'h0010, 4'h0, 32'd0, 2, 32'hDEADBEEF, 1'b0, 3, w);

    // T2: simultaneous requests alternate m0, m1, m0, m1.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      req(1'b0, 1'b0, 16'h0100, 4'h0, 32'd0);
      req(1'b1, 1'b0, 16'h0200, 4'h0, 32'd0);
      serve(1'b0, 1'b0, 16'h0100, 4'h0, 32'd0, 0, 32'h1111_0000 + r, 1'b0, 1, w);
      serve(1'b1, 1'b0, 16'h0200, 4'h0, 32'd0, 1, 32'h2222_0000 + r, 1'b0, 2, w);
    end

    // T3: m0 partial write; m1 read data must be untouched.
    @(negedge clk);
    req(1'b0, 1'b1, 16'h0004, 4'b0011, 32'h0000ABCD);
    serve(1'b0, 1'b1, 16'h0004, 4'b0011, 32'h0000ABCD, 1, 32'hFFFF_FFFF, 1'b0, 2, w);
    chk("m1_rdata_hold", m1_read_data, 32'h2222_0001);
    // Read and write together from one requester act as a write.
    @(negedge clk);
    req(1'b1, 1'b1, 16'h0008, 4'b1100, 32'hCAFE_0000);
    m1_read = 1'b1;
    serve(1'b1, 1'b1, 16'h0008, 4'b1100, 32'hCAFE_0000, 0, 32'h0, 1'b0, 1, w);

    // T4: bridge never acks -> 8 BUSY cycles, error pulse, zeroed data; then normal read.
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0300, 4'h0, 32'd0);
    serve(1'b1, 1'b0, 16'h0300, 4'h0, 32'd0, 0, 32'hBAD0_BAD0, 1'b1, 8, w);
    @(negedge clk);
    req(1'b0, 1'b0, 16'h0304, 4'h0, 32'd0);
    serve(1'b0, 1'b0, 16'h0304, 4'h0, 32'd0, 0, 32'h1234_5678, 1'b0, 1, w);

    // T5: reset mid-BUSY after an m0 grant; afterwards m0 still wins the first tie.
    @(negedge clk);
    req(1'b0, 1'b0, 16'h0400, 4'h0, 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_busy_strobe", {31'd0, sdram_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", {31'd0, sdram_read}, 32'd0);
    drop(1'b0);
    rd_hold[0] = 32'd0;
    rd_hold[1] = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req(1'b0, 1'b0, 16'h0500, 4'h0, 32'd0);
    req(1'b1, 1'b0, 16'h0600, 4'h0, 32'd0);
    serve(1'b0, 1'b0, 16'h0500, 4'h0, 32'd0, 0, 32'hA5A5_0000, 1'b0, 1, w);
    serve(1'b1, 1'b0, 16'h0600, 4'h0, 32'd0, 0, 32'hA5A5_0001, 1'b0, 1, w);

    // T6: spurious bridge ack in IDLE is ignored; the next request starts immediately.
    @(negedge clk);
    sdram_acknowledge = 1'b1;
    @(negedge clk);
    sdram_acknowledge = 1'b0;
    chk("t6_no_strobe", {30'd0, sdram_read, sdram_write}, 32'd0);
    repeat (2) @(negedge clk);
    req(1'b0, 1'b0, 16'h0700, 4'h0, 32'd0);
    serve(1'b0, 1'b0, 16'h0700, 4'h0, 32'd0, 0, 32'h0BAD_F00D, 1'b0, 1, w);
    chk("t6_idle_latency", w, 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
